square_tone_generator: RTL and testbench

- Free-running stereo square-wave test-tone source for the audio peripheral.
- Produces a 32-bit stereo sample word: left channel in [31:16], right channel in [15:0], each 16-bit two's complement.
- The I2S serializer samples this word once per frame, as a drop-in substitute for live audio during bring-up.
- Tone frequency is set by a half-period count in CLK cycles; amplitude is set by parameter.

---
 rtl/square_tone_generator_pkg.sv | 20 ++
 rtl/square_tone_generator_half_period_counter.sv | 32 +++
 rtl/square_tone_generator.sv | 61 ++++++
 tb/tb_square_tone_generator.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/square_tone_generator_pkg.sv
// Shared audio constants and helpers for the square tone generator.
package square_tone_generator_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned FRAME_W  = 32;

    // Left channel in the upper half, right channel in the lower half.
    function automatic logic [FRAME_W-1:0] pack_stereo(
        input logic [SAMPLE_W-1:0] left,
        input logic [SAMPLE_W-1:0] right
    );
        return {left, right};
    endfunction

    // Two's-complement negate, modulo 2^16.
    function automatic logic [SAMPLE_W-1:0] neg16(input logic [SAMPLE_W-1:0] x);
        return (~x) + SAMPLE_W'(1);
    endfunction

endpackage

// File: rtl/square_tone_generator_half_period_counter.sv
// Half-period counter: counts enabled cycles and strobes on the last one.
module square_tone_generator_half_period_counter #(
    parameter int unsigned HALF_PERIOD = 24000,
    parameter int unsigned CNT_W       = 24
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic en,
    output logic wrap
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF_PERIOD - 1);

    logic [CNT_W-1:0] count;

    // Wrap happens only through the compare; the counter never passes LAST.
    assign wrap = en && (count == LAST);

    // Count enabled cycles, restart at zero after the last one of a half-wave.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            count <= '0;
        end else if (en) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/square_tone_generator.sv
// Free-running stereo square-wave test-tone source producing a registered
// 32-bit {left, right} sample word for the I2S serializer.
module square_tone_generator
    import square_tone_generator_pkg::*;
#(
    parameter int unsigned         HALF_PERIOD = 24000,
    parameter logic [SAMPLE_W-1:0] AMPLITUDE   = 16'h1000,
    parameter int unsigned         CNT_W       = 24
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        en,
    input  logic        mute_l,
    input  logic        mute_r,
    output logic [31:0] data,
    output logic        phase,
    output logic        tick
);

    localparam logic [SAMPLE_W-1:0] NEG_AMPLITUDE = neg16(AMPLITUDE);

    logic                wrap;
    logic [SAMPLE_W-1:0] val;
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;

    square_tone_generator_half_period_counter #(
        .HALF_PERIOD (HALF_PERIOD),
        .CNT_W       (CNT_W)
    ) u_half_period_counter (
        .CLK   (CLK),
        .RST_N (RST_N),
        .en    (en),
        .wrap  (wrap)
    );

    // Select the channel value from the pre-edge polarity and apply mutes.
    always_comb begin
        val   = phase ? AMPLITUDE : NEG_AMPLITUDE;
        left  = mute_l ? '0 : val;
        right = mute_r ? '0 : val;
    end

    // Register the sample word, polarity and toggle pulse.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            phase <= 1'b1;
            data  <= '0;
            tick  <= 1'b0;
        end else if (en) begin
            data <= pack_stereo(left, right);
            tick <= wrap;
            if (wrap) begin
                phase <= ~phase;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_square_tone_generator.sv
// Directed self-checking bench for square_tone_generator.
module tb_square_tone_generator;

    logic        CLK;
    logic        RST_N;
    logic        en;
    logic        mute_l;
    logic        mute_r;
    logic [31:0] data;
    logic        phase;
    logic        tick;
    logic [31:0] data_e;
    logic        phase_e;
    logic        tick_e;

    int vectors;
    int miscompares;

    square_tone_generator #(
        .HALF_PERIOD (4),
        .AMPLITUDE   (16'h1000),
        .CNT_W       (24)
    ) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .en     (en),
        .mute_l (mute_l),
        .mute_r (mute_r),
        .data   (data),
        .phase  (phase),
        .tick   (tick)
    );

    square_tone_generator #(
        .HALF_PERIOD (1),
        .AMPLITUDE   (16'h7FFF),
        .CNT_W       (24)
    ) dut_edge (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .en     (en),
        .mute_l (mute_l),
        .mute_r (mute_r),
        .data   (data_e),
        .phase  (phase_e),
        .tick   (tick_e)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        step();
        RST_N = 1'b1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0; en = 1'b1; mute_l = 1'b0; mute_r = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (data !== 32'h0000_0000 || phase !== 1'b1 || tick !== 1'b0) begin
                miscompares++;
                $display("FAIL reset[%0d]: got data=%h phase=%b tick=%b, want data=00000000 phase=1 tick=0",
                         i, data, phase, tick);
            end
        end
        RST_N = 1'b1;
    endtask

    task automatic test_steady();
        logic [31:0] exp_data  [12] = '{32'h10001000, 32'h10001000, 32'h10001000, 32'h10001000,
                                        32'hF000F000, 32'hF000F000, 32'hF000F000, 32'hF000F000,
                                        32'h10001000, 32'h10001000, 32'h10001000, 32'h10001000};
        logic        exp_phase [12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                        1'b1, 1'b1, 1'b1, 1'b0};
        logic        exp_tick  [12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                                        1'b0, 1'b0, 1'b0, 1'b1};
        en = 1'b1; mute_l = 1'b0; mute_r = 1'b0;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step();
            vectors++;
            if (data !== exp_data[i] || phase !== exp_phase[i] || tick !== exp_tick[i]) begin
                miscompares++;
                $display("FAIL steady[%0d]: got data=%h phase=%b tick=%b, want data=%h phase=%b tick=%b",
                         i, data, phase, tick, exp_data[i], exp_phase[i], exp_tick[i]);
            end
        end
    endtask

    task automatic test_enable_gating();
        logic [31:0] exp_data  [3] = '{32'h10001000, 32'h10001000, 32'hF000F000};
        logic        exp_phase [3] = '{1'b1, 1'b0, 1'b0};
        logic        exp_tick  [3] = '{1'b0, 1'b1, 1'b0};
        en = 1'b1; mute_l = 1'b0; mute_r = 1'b0;
        do_reset();
        step();
        step();
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++;
            if (data !== 32'h10001000 || phase !== 1'b1 || tick !== 1'b0) begin
                miscompares++;
                $display("FAIL gated_hold[%0d]: got data=%h phase=%b tick=%b, want data=10001000 phase=1 tick=0",
                         i, data, phase, tick);
            end
        end
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (data !== exp_data[i] || phase !== exp_phase[i] || tick !== exp_tick[i]) begin
                miscompares++;
                $display("FAIL gated_resume[%0d]: got data=%h phase=%b tick=%b, want data=%h phase=%b tick=%b",
                         i, data, phase, tick, exp_data[i], exp_phase[i], exp_tick[i]);
            end
        end
    endtask

    task automatic test_muting();
        logic [31:0] exp_data [8] = '{32'h00001000, 32'h00001000, 32'h00001000, 32'h00001000,
                                      32'h0000F000, 32'h0000F000, 32'h0000F000, 32'h0000F000};
        logic        exp_phase [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic        exp_tick  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        en = 1'b1; mute_l = 1'b1; mute_r = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step();
            vectors++;
            if (data !== exp_data[i] || phase !== exp_phase[i] || tick !== exp_tick[i]) begin
                miscompares++;
                $display("FAIL mute_left[%0d]: got data=%h phase=%b tick=%b, want data=%h phase=%b tick=%b",
                         i, data, phase, tick, exp_data[i], exp_phase[i], exp_tick[i]);
            end
        end
        mute_r = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            vectors++;
            if (data !== 32'h0 || phase !== exp_phase[i] || tick !== exp_tick[i]) begin
                miscompares++;
                $display("FAIL mute_both[%0d]: got data=%h phase=%b tick=%b, want data=00000000 phase=%b tick=%b",
                         i, data, phase, tick, exp_phase[i], exp_tick[i]);
            end
        end
        en = 1'b0; mute_l = 1'b0; mute_r = 1'b0;
        step();
        vectors++;
        if (data !== 32'h0) begin
            miscompares++;
            $display("FAIL mute_change_disabled: got data=%h, want data=00000000", data);
        end
        en = 1'b1;
        step();
        vectors++;
        if (data !== 32'h10001000) begin
            miscompares++;
            $display("FAIL mute_change_reenabled: got data=%h, want data=10001000", data);
        end
    endtask

    task automatic test_reset_midwave();
        en = 1'b1; mute_l = 1'b0; mute_r = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) step();
        vectors++;
        if (data !== 32'hF000F000 || phase !== 1'b0) begin
            miscompares++;
            $display("FAIL midwave_pre: got data=%h phase=%b, want data=F000F000 phase=0", data, phase);
        end
        RST_N = 1'b0;
        step();
        vectors++;
        if (data !== 32'h0 || phase !== 1'b1 || tick !== 1'b0) begin
            miscompares++;
            $display("FAIL midwave_reset: got data=%h phase=%b tick=%b, want data=00000000 phase=1 tick=0",
                     data, phase, tick);
        end
        RST_N = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++;
            if (data !== ((i < 4) ? 32'h10001000 : 32'hF000F000) || tick !== (i == 3)) begin
                miscompares++;
                $display("FAIL midwave_restart[%0d]: got data=%h tick=%b, want data=%h tick=%b",
                         i, data, tick, (i < 4) ? 32'h10001000 : 32'hF000F000, (i == 3));
            end
        end
    endtask

    task automatic test_half_period_one();
        en = 1'b1; mute_l = 1'b0; mute_r = 1'b0;
        do_reset();
        vectors++;
        if (data_e !== 32'h0 || phase_e !== 1'b1 || tick_e !== 1'b0) begin
            miscompares++;
            $display("FAIL hp1_reset: got data=%h phase=%b tick=%b, want data=00000000 phase=1 tick=0",
                     data_e, phase_e, tick_e);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            vectors++;
            if (data_e !== ((i % 2 == 0) ? 32'h7FFF7FFF : 32'h80018001) ||
                phase_e !== (i % 2 == 1) || tick_e !== 1'b1) begin
                miscompares++;
                $display("FAIL hp1[%0d]: got data=%h phase=%b tick=%b, want data=%h phase=%b tick=1",
                         i, data_e, phase_e, tick_e,
                         (i % 2 == 0) ? 32'h7FFF7FFF : 32'h80018001, (i % 2 == 1));
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        RST_N = 1'b0; en = 1'b0; mute_l = 1'b0; mute_r = 1'b0;
        #2;
        test_reset();
        test_steady();
        test_enable_gating();
        test_muting();
        test_reset_midwave();
        test_half_period_one();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
